// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, fixed-latency memory between the instruction-fetch
// port (IF) and the load/store port (LS). At most one access is outstanding at a
// time. Contention is resolved by alternating against the last winner. The
// response is routed back to whichever port owns the outstanding access.
//
// Handshake semantics (both ports):
//   A requester raises *_req and holds it, together with its address, data and
//   controls, until it sees *_gnt high in the same cycle. gnt is combinational
//   from req and is only ever high in an accept cycle. An accept cycle is
//   either an idle cycle or the response cycle of the current access. Exactly
//   MEM_LAT cycles after the grant, the owner's *_rvalid pulses high for one
//   cycle. For loads and fetches it carries the read word. For stores it
//   carries zero. Dropping req before gnt cancels the request without side
//   effects. Changes to req while an access is outstanding are seen only at
//   the next accept cycle.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                top_clk,
    input  logic                top_rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [DATA_W/8-1:0] ls_wstrb,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // A zero-latency memory cannot be modelled by the response counter.
    if (MEM_LAT < 1) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be at least 1");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } port_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    port_e            last_win_q, last_win_d;
    port_e            owner_q, owner_d;
    logic             store_q, store_d;

    logic any_req;
    logic win_ls;
    logic resp;
    logic accept;
    logic grant;

    // Winner selection: a lone requester wins, and on contention the port that did not win last time wins.
    always_comb begin
        any_req = if_req | ls_req;
        win_ls  = 1'b0;
        if (if_req && ls_req) begin
            win_ls = (last_win_q == PORT_IF);
        end else begin
            win_ls = ls_req;
        end
    end

    // FSM next state: count down the outstanding access, and accept a new one when idle or on its response cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_win_d = last_win_q;
        owner_d    = owner_q;
        store_d    = store_q;
        resp       = 1'b0;
        accept     = 1'b0;
        grant      = 1'b0;

        case (state_q)
            S_IDLE: begin
                accept = 1'b1;
            end
            S_WAIT: begin
                resp   = (cnt_q == CNT_ONE);
                accept = resp;
                cnt_d  = cnt_q - CNT_ONE;
                if (resp) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept && any_req) begin
            grant      = 1'b1;
            state_d    = S_WAIT;
            cnt_d      = CNT_LOAD;
            owner_d    = win_ls ? PORT_LS : PORT_IF;
            last_win_d = win_ls ? PORT_LS : PORT_IF;
            store_d    = win_ls & ls_we;
        end
    end

    // Outputs: grant and memory strobes in accept cycles, and the response to the owner; everything is forced low while reset is held.
    always_comb begin
        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        ls_gnt    = 1'b0;
        ls_rvalid = 1'b0;
        ls_rdata  = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;

        if (top_rst) begin
            busy = (state_q == S_WAIT);

            if (resp) begin
                if (owner_q == PORT_IF) begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end else begin
                    ls_rvalid = 1'b1;
                    ls_rdata  = store_q ? '0 : mem_rdata;
                end
            end

            if (grant) begin
                mem_en = 1'b1;
                if (win_ls) begin
                    ls_gnt    = 1'b1;
                    mem_we    = ls_we;
                    mem_wstrb = ls_we ? ls_wstrb : '0;
                    mem_addr  = ls_addr;
                    mem_wdata = ls_wdata;
                end else begin
                    if_gnt   = 1'b1;
                    mem_addr = if_addr;
                end
            end
        end
    end

    // State register: reset returns to IDLE, abandons any in-flight access, and makes IF win the first contention.
    always_ff @(posedge top_clk) begin
        if (!top_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_win_q <= PORT_LS;
            owner_q    <= PORT_IF;
            store_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_win_q <= last_win_d;
            owner_q    <= owner_d;
            store_q    <= store_d;
        end
    end

endmodule
